// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encodings and the
// status-register bit layout used by the MMIO decoder.
package uart_rx_buffered_pkg;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam int unsigned STAT_RX_VALID     = 0;
    localparam int unsigned STAT_FRAMING_ERR  = 1;
    localparam int unsigned STAT_OVERRUN      = 2;

    // Packs receiver flags into the layout the UART status register expects.
    function automatic logic [2:0] pack_status(input logic rx_valid,
                                               input logic framing_error,
                                               input logic overrun);
        logic [2:0] status;
        status = 3'b000;
        status[STAT_RX_VALID]    = rx_valid;
        status[STAT_FRAMING_ERR] = framing_error;
        status[STAT_OVERRUN]     = overrun;
        return status;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// Show-ahead synchronous FIFO; accepts a write while full when a read
// happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_rd;
    logic             do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Empty FIFO presents zero rather than a stale entry.
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 serial receiver with mid-bit sampling, feeding a small show-ahead FIFO
// and reporting framing errors and overruns as single-cycle pulses.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             framing_error_q, framing_error_d;
    logic             overrun_q, overrun_d;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign pop = data_out_ready && !fifo_empty;

    always_comb begin
        state_d         = state_q;
        cnt_d           = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        push            = 1'b0;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q >= SAMPLE_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d   = RX_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q >= SYMBOL_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Leaving at mid-stop-bit lets a following start edge be caught with no gap.
                if (cnt_q >= SYMBOL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (!rx_s_q) begin
                        framing_error_d = 1'b1;
                    end else if (!fifo_full || pop) begin
                        push = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RX_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'h00;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push),
        .din   (shift_q),
        .full  (fifo_full),
        .rd_en (data_out_ready),
        .dout  (data_out),
        .empty (fifo_empty)
    );

    assign data_out_valid = !fifo_empty;
    assign framing_error  = framing_error_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomised self-checking bench for uart_rx_buffered; expected bytes and
// error counts come from a frame-level model of the receiver's rules.
module tb_uart_rx_buffered;

    localparam int unsigned CLK_FREQ  = 1_600_000;
    localparam int unsigned BAUD      = 100_000;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BIT       = CLK_FREQ / BAUD;
    localparam int unsigned SAMPLE    = BIT / 2;
    // Edges from the start-bit drive to the stop-bit sample:
    // 2 synchroniser + 1 idle detect + half bit + 8 data bits + 1 stop bit.
    localparam int unsigned STOP_EDGE = 3 + SAMPLE + 9 * BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_q[$];
    int         fe_cnt;
    int         ov_cnt;

    uart_rx_buffered #(
        .CLOCK_FREQ (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Consumer-side observation: every accepted byte and every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) rx_q.push_back(data_out);
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    task automatic send_bit(input logic v);
        serial_in = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        serial_in = 1'b1;
        repeat (n * BIT) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        data_out_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (data_out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b, expected 0", data_out_valid);
        end
        tests++;
        if (data_out !== 8'h00) begin
            fails++; $display("FAIL reset_data: got %h, expected 00", data_out);
        end
        tests++;
        if ({framing_error, overrun} !== 2'b00) begin
            fails++; $display("FAIL reset_pulses: got %b, expected 00", {framing_error, overrun});
        end
        rst = 1'b0;
        idle_bits(1);
        clear_mon();
    endtask

    task automatic test_single();
        clear_mon();
        data_out_ready = 1'b1;
        fork
            send_frame(8'hAC, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                tests++;
                if (data_out_valid !== 1'b0) begin
                    fails++; $display("FAIL single_early: got valid %b, expected 0", data_out_valid);
                end
                @(posedge clk);
                #1;
                tests++;
                if (data_out_valid !== 1'b1 || data_out !== 8'hAC) begin
                    fails++;
                    $display("FAIL single_latency: got valid %b data %h, expected 1 ac",
                             data_out_valid, data_out);
                end
                @(posedge clk);
                #1;
                tests++;
                if (data_out_valid !== 1'b0) begin
                    fails++; $display("FAIL single_one_cycle: got valid %b, expected 0", data_out_valid);
                end
            end
        join
        idle_bits(1);
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hAC) begin
            fails++; $display("FAIL single_data: got %0d bytes, expected one byte ac", rx_q.size());
        end
        tests++;
        if (fe_cnt != 0 || ov_cnt != 0) begin
            fails++; $display("FAIL single_pulses: got fe %0d ov %0d, expected 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        data_out_ready = 1'b1;
        serial_in = 1'b0;
        repeat (SAMPLE / 2) @(posedge clk);
        #1;
        idle_bits(12);
        tests++;
        if (data_out_valid !== 1'b0 || rx_q.size() != 0 || fe_cnt != 0 || ov_cnt != 0) begin
            fails++;
            $display("FAIL glitch: got valid %b bytes %0d fe %0d ov %0d, expected all 0",
                     data_out_valid, rx_q.size(), fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_framing();
        clear_mon();
        data_out_ready = 1'b0;
        send_frame(8'h41, 1'b0);
        idle_bits(2);
        tests++;
        if (fe_cnt != 1 || ov_cnt != 0) begin
            fails++; $display("FAIL framing_pulse: got fe %0d ov %0d, expected 1 0", fe_cnt, ov_cnt);
        end
        tests++;
        if (data_out_valid !== 1'b0) begin
            fails++; $display("FAIL framing_empty: got valid %b, expected 0", data_out_valid);
        end
        data_out_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        idle_bits(1);
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || fe_cnt != 1) begin
            fails++;
            $display("FAIL framing_recover: got %0d bytes fe %0d, expected one byte 55 fe 1",
                     rx_q.size(), fe_cnt);
        end
    endtask

    task automatic test_overrun();
        clear_mon();
        data_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle_bits(1);
        tests++;
        if (ov_cnt != 1 || fe_cnt != 0) begin
            fails++; $display("FAIL overrun_pulse: got ov %0d fe %0d, expected 1 0", ov_cnt, fe_cnt);
        end
        drain();
        tests++;
        if (rx_q.size() != DEPTH) begin
            fails++; $display("FAIL overrun_count: got %0d bytes, expected %0d", rx_q.size(), DEPTH);
        end
        for (int i = 0; i < rx_q.size() && i < DEPTH; i++) begin
            tests++;
            if (rx_q[i] !== 8'(i + 1)) begin
                fails++; $display("FAIL overrun_order[%0d]: got %h, expected %h", i, rx_q[i], 8'(i + 1));
            end
        end
        tests++;
        if (data_out_valid !== 1'b0) begin
            fails++; $display("FAIL overrun_drained: got valid %b, expected 0", data_out_valid);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q[$];
        clear_mon();
        data_out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'($urandom));
            send_frame(exp_q[i], 1'b1);
        end
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
                @(posedge clk);
                #1;
                data_out_ready = 1'b0;
            end
        join
        idle_bits(1);
        tests++;
        if (ov_cnt != 0) begin
            fails++; $display("FAIL fullpop_overrun: got %0d pulses, expected 0", ov_cnt);
        end
        drain();
        tests++;
        if (rx_q.size() != exp_q.size()) begin
            fails++; $display("FAIL fullpop_count: got %0d bytes, expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL fullpop_order[%0d]: got %h, expected %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial;
        partial = 8'($urandom);
        clear_mon();
        data_out_ready = 1'b0;
        send_frame(8'($urandom), 1'b1);
        idle_bits(1);
        tests++;
        if (data_out_valid !== 1'b1) begin
            fails++; $display("FAIL rstmid_buffered: got valid %b, expected 1", data_out_valid);
        end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        serial_in = partial[4];
        repeat (SAMPLE) @(posedge clk);
        #1;
        rst = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (data_out_valid !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_flush: got valid %b data %h, expected 0 00", data_out_valid, data_out);
        end
        idle_bits(2);
        clear_mon();
        data_out_ready = 1'b1;
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || fe_cnt != 0 || ov_cnt != 0) begin
            fails++;
            $display("FAIL rstmid_recover: got %0d bytes fe %0d ov %0d, expected one byte 3c, 0 0",
                     rx_q.size(), fe_cnt, ov_cnt);
        end
    endtask

    // Back-to-back and gapped random frames with a always-ready consumer.
    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        clear_mon();
        data_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'($urandom));
            send_frame(exp_q[i], 1'b1);
            if ($urandom_range(0, 1) == 1) idle_bits(int'($urandom_range(1, 2)));
        end
        idle_bits(1);
        tests++;
        if (rx_q.size() != exp_q.size() || fe_cnt != 0 || ov_cnt != 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d bytes fe %0d ov %0d, expected %0d 0 0",
                     rx_q.size(), fe_cnt, ov_cnt, exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL b2b_data[%0d]: got %h, expected %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    // Stalled consumer: the first DEPTH bytes survive, the rest each raise overrun.
    task automatic test_random_overrun();
        for (int r = 0; r < 3; r++) begin
            logic [7:0] sent[$];
            int         k;
            int         keep;
            k = int'($urandom_range(1, 7));
            keep = (k > int'(DEPTH)) ? int'(DEPTH) : k;
            clear_mon();
            data_out_ready = 1'b0;
            for (int i = 0; i < k; i++) begin
                sent.push_back(8'($urandom));
                send_frame(sent[i], 1'b1);
            end
            idle_bits(1);
            tests++;
            if (ov_cnt != k - keep) begin
                fails++; $display("FAIL rndov_pulses: got %0d, expected %0d", ov_cnt, k - keep);
            end
            drain();
            tests++;
            if (rx_q.size() != keep) begin
                fails++; $display("FAIL rndov_count: got %0d bytes, expected %0d", rx_q.size(), keep);
            end
            for (int i = 0; i < rx_q.size() && i < keep; i++) begin
                tests++;
                if (rx_q[i] !== sent[i]) begin
                    fails++; $display("FAIL rndov_data[%0d]: got %h, expected %h", i, rx_q[i], sent[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        test_random_overrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
